// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, field widths and the
// ID/EX field record used by the decode-to-execute stage.
package pipe_pkg;

   localparam int DATA_W  = 32;
   localparam int OPC_W   = 6;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rd;
      logic [SHAMT_W-1:0] shamt;
      logic [FUNCT_W-1:0] funct;
      logic [DATA_W-1:0]  imm32;
      logic [DATA_W-1:0]  pcPlus4;
      logic               memRead;
   } idex_t;

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic ext_sign(input logic [OPC_W-1:0] op);
      logic s;
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: s = 1'b0;
         default:                  s = 1'b1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-stage / ID-EX bus bundle. The master modport is the stage itself,
// the slave modport is its surroundings (IF/ID, extender, execute stage).
interface id_ex_stage_if;
   import pipe_pkg::*;

   logic                 idValid;
   logic [DATA_W-1:0]    idInstr;
   logic [DATA_W-1:0]    idPcPlus4;
   logic                 idReady;
   logic                 extOp;
   logic [IMM_W-1:0]     imm16;
   logic [DATA_W-1:0]    imm32;
   logic                 exReady;
   logic                 flush;
   logic                 exValid;
   logic [OPC_W-1:0]     exOpcode;
   logic [REG_W-1:0]     exRs;
   logic [REG_W-1:0]     exRt;
   logic [REG_W-1:0]     exRd;
   logic [SHAMT_W-1:0]   exShamt;
   logic [FUNCT_W-1:0]   exFunct;
   logic [DATA_W-1:0]    exImm32;
   logic [DATA_W-1:0]    exPcPlus4;
   logic                 exMemRead;
   logic                 loadUseStall;

   modport master (
      input  idValid, idInstr, idPcPlus4, imm32, exReady, flush,
      output idReady, extOp, imm16, exValid, exOpcode, exRs, exRt, exRd,
             exShamt, exFunct, exImm32, exPcPlus4, exMemRead, loadUseStall
   );

   modport slave (
      output idValid, idInstr, idPcPlus4, imm32, exReady, flush,
      input  idReady, extOp, imm16, exValid, exOpcode, exRs, exRt, exRd,
             exShamt, exFunct, exImm32, exPcPlus4, exMemRead, loadUseStall
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: the load sitting in ID/EX writes a register
// that the instruction in ID wants to read. r0 never creates a hazard.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic             exValid,
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exRt,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic             idValid,
   output logic             loadUse
);

   assign loadUse = exValid & exMemRead & (exRt != '0) & idValid &
                    ((exRt == rs) | (exRt == rt));

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: splits the ID instruction into fields, drives the
// external immediate extender, and registers everything into ID/EX with
// valid/ready flow control, flush and load-use bubble insertion.
// Build option: define LOAD_USE_DETECT_EN to enable load-use hazard
// detection; without it loadUse is tied low and the compiler must pad loads.
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.master bus
);

   idex_t dec_p0;
   idex_t idex_p1;
   logic  vld_p1;
   logic  adv;
   logic  loadUse;

   // Field split of the ID instruction; imm32 returns from the extender
   always_comb begin
      dec_p0         = '0;
      dec_p0.opcode  = bus.idInstr[31:26];
      dec_p0.rs      = bus.idInstr[25:21];
      dec_p0.rt      = bus.idInstr[20:16];
      dec_p0.rd      = bus.idInstr[15:11];
      dec_p0.shamt   = bus.idInstr[10:6];
      dec_p0.funct   = bus.idInstr[5:0];
      dec_p0.imm32   = bus.imm32;
      dec_p0.pcPlus4 = bus.idPcPlus4;
      dec_p0.memRead = (bus.idInstr[31:26] == OP_LW);
   end

   assign bus.extOp = ext_sign(bus.idInstr[31:26]);
   assign bus.imm16 = bus.idInstr[15:0];

   // ID/EX can take a new entry when empty or when execute drains it
   assign adv = bus.exReady | ~vld_p1;

`ifdef LOAD_USE_DETECT_EN
   load_use_detect u_load_use_detect (
      .exValid   (vld_p1),
      .exMemRead (idex_p1.memRead),
      .exRt      (idex_p1.rt),
      .rs        (dec_p0.rs),
      .rt        (dec_p0.rt),
      .idValid   (bus.idValid),
      .loadUse   (loadUse)
   );
`else
   assign loadUse = 1'b0;
`endif

   // A flush always lets ID drop its instruction, hazard or not
   assign bus.loadUseStall = loadUse & ~bus.flush;
   assign bus.idReady      = bus.flush | (adv & ~loadUse);

   // ID/EX register: flush kills, advance loads (bubble clears memRead), else hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         idex_p1 <= '0;
      end else if (bus.flush) begin
         vld_p1  <= 1'b0;
      end else if (adv) begin
         vld_p1          <= bus.idValid & ~loadUse;
         idex_p1         <= dec_p0;
         idex_p1.memRead <= dec_p0.memRead & bus.idValid & ~loadUse;
      end
   end

   assign bus.exValid   = vld_p1;
   assign bus.exOpcode  = idex_p1.opcode;
   assign bus.exRs      = idex_p1.rs;
   assign bus.exRt      = idex_p1.rt;
   assign bus.exRd      = idex_p1.rd;
   assign bus.exShamt   = idex_p1.shamt;
   assign bus.exFunct   = idex_p1.funct;
   assign bus.exImm32   = idex_p1.imm32;
   assign bus.exPcPlus4 = idex_p1.pcPlus4;
   assign bus.exMemRead = idex_p1.memRead;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits between the IF/ID register and the execute stage. It takes the fetched instruction and splits it into fields. It drives the immediate extender (`extOp`, `imm16`) and consumes its `imm32` result. All decoded fields are registered into the ID/EX pipeline register, with valid/ready flow control, flush, and load-use bubble insertion.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `idValid`  in  1  IF/ID holds a valid instruction.
- `idInstr`  in  32  instruction word.
- `idPcPlus4`  in  32  PC+4 of that instruction.
- `idReady`  out  1  ID stage consumes `idInstr` this cycle.
- `extOp`  out  1  to extender; 1 = sign-extend, 0 = zero-extend (combinational).
- `imm16`  out  16  to extender, `idInstr[15:0]` (combinational).
- `imm32`  in  32  from extender, same cycle.
- `exReady`  in  1  execute stage accepts the ID/EX contents.
- `flush`  in  1  kill the ID-stage instruction (branch/jump redirect).
- `exValid`  out  1  ID/EX holds a valid instruction.
- `exOpcode`  out  6  registered `idInstr[31:26]`.
- `exRs`, `exRt`, `exRd`  out  5 each  registered register fields.
- `exShamt`  out  5  registered `[10:6]`.
- `exFunct`  out  6  registered `[5:0]`.
- `exImm32`  out  32  registered `imm32`.
- `exPcPlus4`  out  32  registered `idPcPlus4`.
- `exMemRead`  out  1  registered; 1 when opcode = LW (0x23).
- `loadUseStall`  out  1  combinational hazard indication, for PC/IF-ID hold.

## Operation
- extOp = 0 for ANDI (0x0C), ORI (0x0D), XORI (0x0E). extOp = 1 for every other opcode.
- adv = exReady | ~exValid.
- loadUse = exValid & exMemRead & (exRt != 0) & idValid & ((exRt == rs) | (exRt == rt)).
- loadUseStall = loadUse & ~flush.
- idReady = flush | (adv & ~loadUse).
- On a clock edge with flush = 1, exValid <= 0. The other ex* fields are don't-care.
- Otherwise, with adv = 1:
  - exValid <= idValid & ~loadUse.
  - All fields load from the current instruction, even when the result is a bubble.
- Otherwise (no flush, adv = 0): all ID/EX registers hold.
- Bubble: exValid = 0 and exMemRead = 0. Forcing exMemRead low guarantees the hazard clears after exactly one bubble.
- Flush has priority over loadUse and over exReady = 0.
- Reset: every registered output is 0, including exValid, exImm32 and exPcPlus4.
  - The combinational outputs follow `idInstr`.
  - Reset released mid-stream: the first edge after release behaves as an empty ID/EX.

## Timing
- Latency: 1 cycle from idValid & idReady to the fields appearing on ex*.
- `imm16`/`extOp` to `imm32` is a purely combinational path, captured on the same edge.
- `idReady`, `loadUseStall`, `extOp` and `imm16` are combinational. There is no combinational path from `exReady` into `extOp` or `imm16`.
- Load-use costs exactly one bubble cycle when exReady = 1.
- If exReady = 0 while a hazard is present, the stall persists until the load advances.
- Back-to-back instructions with no hazard and exReady held high flow at 1 per cycle.

## Configuration
- `LOAD_USE_DETECT_EN` defined: hazard logic as above.
- `LOAD_USE_DETECT_EN` undefined:
  - loadUse is tied to 0 and loadUseStall = 0.
  - exMemRead is still produced.
  - Hazards are then handled by compiler NOP insertion.

## Structure
- Shared package `pipe_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_BEQ;
  - field width constants;
  - the ID/EX field record typedef.
- One sub-module, `load_use_detect`: inputs exValid, exMemRead, exRt, rs, rt, idValid; output loadUse. It is instantiated only under `LOAD_USE_DETECT_EN`.
- The extender stays external; this block only connects to it.

## Test plan
- Reset: assert rst_n = 0 mid-stream -> all ex* = 0 immediately. After release, the first valid ADDI is captured on the next edge.
- ADDI r1,r0,0xFFFF with exReady = 1 -> extOp = 1, and exImm32 = 0xFFFFFFFF one cycle later.
- ORI r1,r0,0x8001 -> extOp = 0, exImm32 = 0x00008001, exRt = 1.
- LW r2,0(r1), then ADD r3,r2,r4 -> loadUseStall = 1 for one cycle, one bubble (exValid = 0), then ADD is captured. With the macro undefined there is no bubble.
- exReady = 0 for 3 cycles with exValid = 1 -> all ex* hold and idReady = 0. Resumes with no loss or duplication.
- flush = 1 in the same cycle as a load-use hazard and exReady = 0 -> idReady = 1, and exValid = 0 next cycle.
